// File: rtl/rtc_pkg.sv
// Shared widths, limits and the packed time type for the real-time clock.
// Hours are kept in 24h form; to_12h derives the 12h display form.
package rtc_pkg;

  localparam int SEC_W = 6;
  localparam int MIN_W = 6;
  localparam int HR_W  = 5;

  localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;
  localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;

  typedef struct packed {
    logic [HR_W-1:0]  hr;
    logic [MIN_W-1:0] min;
    logic [SEC_W-1:0] sec;
  } rtc_time_t;

  // Returns {pm, display hour} for a 24h hour value.
  function automatic logic [HR_W:0] to_12h(input logic [HR_W-1:0] hr24);
    logic [HR_W:0] res;
    if (hr24 == 5'd0) begin
      res = {1'b0, 5'd12};
    end else if (hr24 > 5'd12) begin
      res = {1'b1, hr24 - 5'd12};
    end else if (hr24 == 5'd12) begin
      res = {1'b1, 5'd12};
    end else begin
      res = {1'b0, hr24};
    end
    return res;
  endfunction

endpackage

// File: rtl/rtc_counter_mod_n.sv
// Wrapping 0..MAX counter with synchronous load; carry is asserted
// combinationally when an increment wraps the counter back to zero.
module mod_n_counter
  import rtc_pkg::*;
#(
  parameter int W   = 6,
  parameter int MAX = 59
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] value,
  output logic         carry
);

  localparam logic [W-1:0] MAX_V = W'(MAX);
  localparam logic [W-1:0] ONE_V = W'(1);

  logic [W-1:0] value_r;
  logic         at_max_s;

  assign at_max_s = (value_r == MAX_V);
  assign carry    = inc & at_max_s;
  assign value    = value_r;

  // Counter register: load wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_r <= '0;
    end else if (load) begin
      value_r <= load_val;
    end else if (inc) begin
      value_r <= at_max_s ? '0 : value_r + ONE_V;
    end else begin
      value_r <= value_r;
    end
  end

endmodule

// File: rtl/rtc_counter.sv
// Real-time clock: prescaler plus sec/min/hr chain with load and 12h display.
// Optional alarm enabled by defining RTC_COUNTER_ALARM_EN.
module rtc_counter
  import rtc_pkg::*;
#(
  parameter int PRESCALE = 100000000,
  parameter int HR_MAX   = 23
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef RTC_COUNTER_ALARM_EN
  input  logic             alarm_set,
  input  logic [HR_W-1:0]  alarm_hr,
  input  logic [MIN_W-1:0] alarm_min,
  input  logic             alarm_clr,
  output logic             alarm_hit,
`endif
  input  logic             en,
  input  logic             load,
  input  logic [SEC_W-1:0] load_sec,
  input  logic [MIN_W-1:0] load_min,
  input  logic [HR_W-1:0]  load_hr,
  input  logic             mode_12h,
  output logic [SEC_W-1:0] sec,
  output logic [MIN_W-1:0] min,
  output logic [HR_W-1:0]  hr,
  output logic [HR_W-1:0]  disp_hr,
  output logic             pm,
  output logic             sec_tick,
  output logic             day_wrap,
  output logic             load_err
);

  localparam int              PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [PS_W-1:0] PS_ONE  = PS_W'(1);
  localparam logic [HR_W-1:0] HR_LAST = HR_W'(HR_MAX);
  localparam bit              HAS_12H = (HR_MAX == 23);

  logic [PS_W-1:0] ps_r;
  logic            load_ok_s;
  logic            tick_s;
  logic            sec_carry_s;
  logic            min_carry_s;
  logic            hr_carry_s;
  logic            sec_tick_r;
  logic            day_wrap_r;
  logic            load_err_r;
  logic [HR_W-1:0] disp_hr_s;
  logic            pm_s;
  rtc_time_t       cur_s;

  assign load_ok_s = load && (load_sec <= SEC_MAX) && (load_min <= MIN_MAX)
                     && (load_hr <= HR_LAST);
  // Any load, valid or not, suppresses the tick for that cycle.
  assign tick_s    = en && !load && (ps_r == PS_LAST);

  // Prescaler: cleared by a valid load, frozen by a rejected one or en=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps_r <= '0;
    end else if (load) begin
      ps_r <= load_ok_s ? '0 : ps_r;
    end else if (en) begin
      ps_r <= (ps_r == PS_LAST) ? '0 : ps_r + PS_ONE;
    end else begin
      ps_r <= ps_r;
    end
  end

  mod_n_counter #(.W(SEC_W), .MAX(59)) u_sec (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (tick_s),
    .load     (load_ok_s),
    .load_val (load_sec),
    .value    (cur_s.sec),
    .carry    (sec_carry_s)
  );

  mod_n_counter #(.W(MIN_W), .MAX(59)) u_min (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (sec_carry_s),
    .load     (load_ok_s),
    .load_val (load_min),
    .value    (cur_s.min),
    .carry    (min_carry_s)
  );

  mod_n_counter #(.W(HR_W), .MAX(HR_MAX)) u_hr (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (min_carry_s),
    .load     (load_ok_s),
    .load_val (load_hr),
    .value    (cur_s.hr),
    .carry    (hr_carry_s)
  );

  // Registered status pulses and the sticky load error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_tick_r <= 1'b0;
      day_wrap_r <= 1'b0;
      load_err_r <= 1'b0;
    end else begin
      sec_tick_r <= tick_s;
      day_wrap_r <= hr_carry_s;
      if (load) begin
        load_err_r <= !load_ok_s;
      end else begin
        load_err_r <= load_err_r;
      end
    end
  end

  // Display hour: 12h conversion only for a 24-hour day.
  always_comb begin
    disp_hr_s = cur_s.hr;
    pm_s      = 1'b0;
    if (HAS_12H && mode_12h) begin
      {pm_s, disp_hr_s} = to_12h(cur_s.hr);
    end else begin
      disp_hr_s = cur_s.hr;
      pm_s      = 1'b0;
    end
  end

  assign sec      = cur_s.sec;
  assign min      = cur_s.min;
  assign hr       = cur_s.hr;
  assign disp_hr  = disp_hr_s;
  assign pm       = pm_s;
  assign sec_tick = sec_tick_r;
  assign day_wrap = day_wrap_r;
  assign load_err = load_err_r;

`ifdef RTC_COUNTER_ALARM_EN
  logic             armed_r;
  logic [HR_W-1:0]  al_hr_r;
  logic [MIN_W-1:0] al_min_r;
  logic             alarm_hit_r;
  logic [MIN_W-1:0] next_min_s;
  logic [HR_W-1:0]  next_hr_s;
  logic             match_s;

  // Time reached when the current minute rolls over (only relevant at sec=59).
  always_comb begin
    next_min_s = cur_s.min;
    next_hr_s  = cur_s.hr;
    if (cur_s.min == MIN_MAX) begin
      next_min_s = '0;
      next_hr_s  = (cur_s.hr == HR_LAST) ? '0 : cur_s.hr + 5'd1;
    end else begin
      next_min_s = cur_s.min + 6'd1;
      next_hr_s  = cur_s.hr;
    end
  end

  assign match_s = tick_s && armed_r && (cur_s.sec == SEC_MAX)
                   && (next_min_s == al_min_r) && (next_hr_s == al_hr_r);

  // Alarm arming (clear wins) and registered hit pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_r     <= 1'b0;
      al_hr_r     <= '0;
      al_min_r    <= '0;
      alarm_hit_r <= 1'b0;
    end else begin
      alarm_hit_r <= match_s;
      if (alarm_clr) begin
        armed_r <= 1'b0;
      end else if (alarm_set) begin
        armed_r  <= 1'b1;
        al_hr_r  <= alarm_hr;
        al_min_r <= alarm_min;
      end else begin
        armed_r <= armed_r;
      end
    end
  end

  assign alarm_hit = alarm_hit_r;
`endif

endmodule
